// File: rtl/row_fetch_ctrl.sv
// row_fetch_ctrl: fetches one 10-cell board row from the shared single-port
// board memory into the Row buffer read by color_mapper, triggered on hsync
// rising edges at block-row boundaries. Display fetches own the memory port
// while a fetch is in flight; game-logic requests are granted only in IDLE.
// Optional feature macro: ROWFETCH_OVERRUN_CNT_EN adds an 8-bit saturating
// overrun event counter on port overrun_cnt.
module row_fetch_ctrl #(
  parameter int SQUARE_SIZE = 21,
  parameter int BOARD_ROWS  = 20,
  parameter int BOARD_COLS  = 10,
  parameter int LAST_LINE   = 479
) (
  input  logic                           Clk,
  input  logic                           reset,
  input  logic                           hs,
  input  logic [9:0]                     DrawY,
  output logic [8:0]                     mem_addr,
  output logic                           mem_rd,
  output logic                           mem_we,
  output logic [15:0]                    mem_wdata,
  input  logic [15:0]                    mem_rdata,
  input  logic                           gl_req,
  input  logic                           gl_we,
  input  logic [8:0]                     gl_addr,
  input  logic [15:0]                    gl_wdata,
  output logic                           gl_gnt,
  output logic [15:0]                    gl_rdata,
  output logic                           gl_rvalid,
  output logic [BOARD_COLS-1:0][15:0]    Row,
  output logic                           rowReady,
  output logic [4:0]                     rowNum,
  output logic                           fetch_overrun
`ifdef ROWFETCH_OVERRUN_CNT_EN
  ,
  output logic [7:0]                     overrun_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_t;

  // 10-bit versions of the geometry so the trigger arithmetic stays 10-bit
  localparam logic [9:0] SQ_W     = 10'(SQUARE_SIZE);
  localparam logic [9:0] ROWS_W   = 10'(BOARD_ROWS);
  localparam logic [9:0] LAST_W   = 10'(LAST_LINE);
  localparam logic [3:0] LAST_COL = 4'(BOARD_COLS - 1);

  state_t                        state_q, state_d;
  logic                          hs_q;
  logic [3:0]                    col_q, col_d;
  logic [4:0]                    tgt_q, tgt_d;
  logic                          rd_pend_q;
  logic [3:0]                    rd_col_q;
  logic [BOARD_COLS-1:0][15:0]   shadow_q, shadow_d;
  logic [BOARD_COLS-1:0][15:0]   row_q;
  logic [4:0]                    rownum_q;
  logic                          rowready_q;
  logic                          overrun_q;
  logic                          gl_rvalid_q;

  logic [9:0]                    y_next, quot, rem;
  logic                          trig_hit;
  logic [4:0]                    trig_row;
  logic                          trigger, hs_fall;
  logic                          commit, overrun_evt;
  logic                          gnt;

  // Decode which block row (if any) must be loaded for the line after DrawY.
  // DrawY < LAST_LINE whenever DrawY+1 is used, so the add cannot wrap.
  always_comb begin
    y_next   = DrawY + 10'd1;
    quot     = y_next / SQ_W;
    rem      = y_next % SQ_W;
    trig_hit = 1'b0;
    trig_row = '0;
    if (DrawY >= LAST_W) begin
      trig_hit = 1'b1;
    end else if (rem == 10'd0 && quot < ROWS_W) begin
      trig_hit = 1'b1;
      trig_row = quot[4:0];
    end
  end

  assign trigger = hs & ~hs_q & trig_hit;
  assign hs_fall = ~hs & hs_q;

  // Fetch sequencer: next state, column counter, and overrun detection.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    tgt_d       = tgt_q;
    commit      = 1'b0;
    overrun_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = ISSUE;
          col_d   = '0;
          tgt_d   = trig_row;
        end
      end
      ISSUE: begin
        if (hs_fall) begin
          state_d     = IDLE;
          overrun_evt = 1'b1;
        end else begin
          col_d = col_q + 4'd1;
          if (col_q == LAST_COL) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (hs_fall) begin
          state_d     = IDLE;
          overrun_evt = 1'b1;
        end else begin
          // Row is loaded on the way into COMMIT so it is visible there
          state_d = COMMIT;
          commit  = 1'b1;
        end
      end
      COMMIT: begin
        // An hs fall here is expected line timing, not an overrun
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new boundary arriving while still busy means the fetch fell behind
    if (trigger && state_q != IDLE) overrun_evt = 1'b1;
  end

  // Merge the read returning this cycle into the shadow row.
  always_comb begin
    shadow_d = shadow_q;
    if (rd_pend_q && rd_col_q <= LAST_COL) shadow_d[rd_col_q] = mem_rdata;
  end

  // Memory port mux: fetch reads own the port outside IDLE, game logic in IDLE.
  always_comb begin
    gnt       = 1'b0;
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (!reset) begin
      if (state_q == ISSUE) begin
        mem_rd   = 1'b1;
        mem_addr = {tgt_q, col_q};
      end else if (state_q == IDLE && gl_req) begin
        gnt       = 1'b1;
        mem_addr  = gl_addr;
        mem_we    = gl_we;
        mem_rd    = ~gl_we;
        mem_wdata = gl_wdata;
      end
    end
  end

  // State, fetch bookkeeping, committed row and status registers.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hs_q        <= 1'b0;
      col_q       <= '0;
      tgt_q       <= '0;
      rd_pend_q   <= 1'b0;
      rd_col_q    <= '0;
      shadow_q    <= '0;
      row_q       <= '0;
      rownum_q    <= '0;
      rowready_q  <= 1'b0;
      overrun_q   <= 1'b0;
      gl_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hs_q        <= hs;
      col_q       <= col_d;
      tgt_q       <= tgt_d;
      rd_pend_q   <= (state_q == ISSUE);
      rd_col_q    <= col_q;
      shadow_q    <= shadow_d;
      rowready_q  <= commit;
      overrun_q   <= overrun_q | overrun_evt;
      gl_rvalid_q <= gnt & ~gl_we;
      if (commit) begin
        row_q    <= shadow_d;
        rownum_q <= tgt_q;
      end
    end
  end

`ifdef ROWFETCH_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q;

  // Saturating count of overrun events.
  always_ff @(posedge Clk) begin
    if (reset)                              ovr_cnt_q <= '0;
    else if (overrun_evt && ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
  end

  assign overrun_cnt = ovr_cnt_q;
`endif

  assign gl_gnt        = gnt;
  assign gl_rvalid     = gl_rvalid_q;
  assign gl_rdata      = gl_rvalid_q ? mem_rdata : 16'h0000;
  assign Row           = row_q;
  assign rowReady      = rowready_q;
  assign rowNum        = rownum_q;
  assign fetch_overrun = overrun_q;

endmodule
